seq_101_gen: RTL

SEQ_101_GEN -- requirements
Module: seq_101_gen

---
 rtl/seq_101_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_101_gen.sv
// seq_101_gen: stimulus generator for a serial "101" detector.
// Accepts a WIDTH-bit word when idle and transmits it MSB first on d_out,
// one bit per cycle, with d_valid marking payload bits. A one-cycle done
// pulse follows the last bit. All outputs come straight from flops.
//
// Optional feature (macro SEQ_GEN_COUNT_EN): exp_count reports how many
// "101" patterns (overlapping, across word boundaries) have been sent since
// reset, saturating at 255.
//
// Ports:
//   clock       rising-edge clock
//   rst         synchronous active-high reset
//   load_valid  word offered for transmission
//   load_data   word to serialize (MSB first)
//   load_ready  generator accepts a word this cycle
//   d_out       serial bit stream
//   d_valid     d_out carries a payload bit
//   done        one-cycle pulse after the last bit of a word
//   exp_count   expected 101-detection count (SEQ_GEN_COUNT_EN only)
module seq_101_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             d_out,
  output logic             d_valid,
  output logic             done
`ifdef SEQ_GEN_COUNT_EN
  ,
  output logic [7:0]       exp_count
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    bit_cnt;

  // d_out is the shift-register MSB. Zeros shift in behind the payload, so
  // after WIDTH shifts the register is empty and d_out rests at 0 in
  // DONE and IDLE without extra gating.
  assign d_out = sr[WIDTH-1];

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      load_ready <= 1'b1;
      d_valid    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            sr         <= load_data;
            bit_cnt    <= '0;
            state      <= SHIFT;
            load_ready <= 1'b0;
            d_valid    <= 1'b1;
          end
        end
        SHIFT: begin
          sr <= {sr[WIDTH-2:0], 1'b0};
          if (bit_cnt == LAST) begin
            state   <= DONE;
            d_valid <= 1'b0;
            done    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          sr         <= '0;
          load_ready <= 1'b1;
          d_valid    <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_GEN_COUNT_EN
  // The 3-bit history window is the two previously sent bits plus the bit
  // currently on d_out; matching it here makes exp_count move on the cycle
  // after the completing bit.
  logic [1:0] hist;
  logic [2:0] window;

  assign window = {hist, d_out};

  always_ff @(posedge clock) begin
    if (rst) begin
      hist      <= '0;
      exp_count <= '0;
    end else if (d_valid) begin
      hist <= window[1:0];
      if (window == 3'b101 && exp_count != 8'hFF) begin
        exp_count <= exp_count + 8'd1;
      end
    end
  end
`endif

endmodule
